// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: shared ROB/RS sizing constants and decoder instruction type codes
package rob_commit_pkg;
  localparam int ROB_SIZE = 16;
  localparam int ROB_W = 4;
  localparam int RS_SIZE = 16;
  localparam int RS_W = 4;
  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_STORE  = 2'd1,
    T_BRANCH = 2'd2,
    T_JALR   = 2'd3
  } dc_type_e;
endpackage

// File: rtl/rob_commit.sv
// rob_commit: circular reorder buffer with in-order retirement and branch/JALR flush
// ports: clk_in/rst_n_in/rdy_in control; dc_* issue; rs_*/lsb_* result broadcasts;
// q1/q2 operand queries; commit_* registered retirement; rob_clear/clear_pc flush pulse
module rob_commit #(
  parameter int ROB_SIZE = rob_commit_pkg::ROB_SIZE,
  parameter int ROB_W = rob_commit_pkg::ROB_W
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             dc_valid,
  input  logic [1:0]       dc_type,
  input  logic [4:0]       dc_rd,
  input  logic             dc_pred_taken,
  input  logic [31:0]      dc_alt_pc,
  output logic             rob_full,
  output logic [ROB_W-1:0] rob_tail_id,
  input  logic             rs_has_output,
  input  logic [ROB_W-1:0] rs_rob_id,
  input  logic [31:0]      rs_output,
  input  logic [31:0]      jalr_new_pc,
  input  logic             is_lsb,
  input  logic [ROB_W-1:0] lsb_rob_id,
  input  logic [31:0]      lsb_res,
  input  logic [ROB_W-1:0] q1_id,
  input  logic [ROB_W-1:0] q2_id,
  output logic             q1_ready,
  output logic             q2_ready,
  output logic [31:0]      q1_val,
  output logic [31:0]      q2_val,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic [ROB_W-1:0] commit_id,
  output logic             commit_store,
  output logic             rob_clear,
  output logic [31:0]      clear_pc
);
  import rob_commit_pkg::*;
  logic [ROB_SIZE-1:0] busy, ready, pred, tail_oh, head_oh;
  logic [1:0] typ [ROB_SIZE];
  logic [4:0] rd [ROB_SIZE];
  logic [31:0] alt_pc [ROB_SIZE];
  logic [31:0] value [ROB_SIZE];
  logic [31:0] target [ROB_SIZE];
  logic [ROB_W-1:0] head, tail;
  logic [ROB_W:0] count;
  logic issue, commit, flush;
  assign rob_full = count == (ROB_W+1)'(ROB_SIZE);
  assign rob_tail_id = tail;
  assign q1_ready = busy[q1_id] && ready[q1_id];
  assign q2_ready = busy[q2_id] && ready[q2_id];
  assign q1_val = value[q1_id];
  assign q2_val = value[q2_id];
  assign issue = dc_valid && !rob_full;
  assign commit = busy[head] && ready[head];
  // head and tail can only coincide when empty (no commit) or full (no issue)
  assign tail_oh = ROB_SIZE'(issue) << tail;
  assign head_oh = ROB_SIZE'(commit) << head;
  assign flush = commit && (typ[head] == T_JALR || (typ[head] == T_BRANCH && value[head][0] != pred[head]));
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      busy <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      commit_valid <= 1'b0;
      commit_store <= 1'b0;
      rob_clear <= 1'b0;
      commit_rd <= '0;
      commit_val <= '0;
      commit_id <= '0;
      clear_pc <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        busy <= '0;
        head <= '0;
        tail <= '0;
        count <= '0;
        commit_valid <= 1'b0;
        commit_store <= 1'b0;
        rob_clear <= 1'b0;
      end else begin
        busy <= (busy | tail_oh) & ~head_oh;
        head <= head + ROB_W'(commit);
        tail <= tail + ROB_W'(issue);
        count <= count + (ROB_W+1)'(issue) - (ROB_W+1)'(commit);
        commit_valid <= commit;
        commit_store <= commit && typ[head] == T_STORE;
        rob_clear <= flush;
        if (commit) begin
          commit_rd <= typ[head] == T_BRANCH ? 5'd0 : rd[head];
          commit_val <= value[head];
          commit_id <= head;
        end
        if (flush) clear_pc <= typ[head] == T_JALR ? target[head] : alt_pc[head];
      end
    end
  // payload needs no reset: busy gates every use of it
  always_ff @(posedge clk_in)
    if (rdy_in && !rob_clear) begin
      if (is_lsb && busy[lsb_rob_id]) begin
        ready[lsb_rob_id] <= 1'b1;
        value[lsb_rob_id] <= lsb_res;
      end
      if (rs_has_output && busy[rs_rob_id]) begin
        ready[rs_rob_id] <= 1'b1;
        value[rs_rob_id] <= rs_output;
        target[rs_rob_id] <= jalr_new_pc;
      end
      if (issue) begin
        ready[tail] <= dc_type == T_STORE;
        typ[tail] <= dc_type;
        rd[tail] <= dc_rd;
        pred[tail] <= dc_pred_taken;
        alt_pc[tail] <= dc_alt_pc;
        value[tail] <= '0;
        target[tail] <= '0;
      end
    end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: randomized and directed checks of rob_commit against a queue-based reference model
module tb_rob_commit;
  localparam int N = 16;
  logic clk_in = 0, rst_n_in = 0, rdy_in = 1;
  logic dc_valid = 0, dc_pred_taken = 0, rs_has_output = 0, is_lsb = 0;
  logic [1:0] dc_type = 0;
  logic [4:0] dc_rd = 0;
  logic [31:0] dc_alt_pc = 0, rs_output = 0, jalr_new_pc = 0, lsb_res = 0;
  logic [3:0] rs_rob_id = 0, lsb_rob_id = 0, q1_id = 0, q2_id = 0;
  logic rob_full, q1_ready, q2_ready, commit_valid, commit_store, rob_clear;
  logic [3:0] rob_tail_id, commit_id;
  logic [31:0] q1_val, q2_val, commit_val, clear_pc;
  logic [4:0] commit_rd;
  always #5 clk_in = ~clk_in;
  rob_commit dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .dc_valid(dc_valid), .dc_type(dc_type), .dc_rd(dc_rd), .dc_pred_taken(dc_pred_taken), .dc_alt_pc(dc_alt_pc),
    .rob_full(rob_full), .rob_tail_id(rob_tail_id),
    .rs_has_output(rs_has_output), .rs_rob_id(rs_rob_id), .rs_output(rs_output), .jalr_new_pc(jalr_new_pc),
    .is_lsb(is_lsb), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready), .q1_val(q1_val), .q2_val(q2_val),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val), .commit_id(commit_id),
    .commit_store(commit_store), .rob_clear(rob_clear), .clear_pc(clear_pc)
  );
  int checks = 0, errors = 0;
  typedef struct {
    logic rdy;
    logic [1:0] t;
    logic [4:0] rd;
    logic p;
    logic [31:0] alt, val, tgt;
  } ent_t;
  ent_t e [N];
  int q[$];
  int mtail;
  logic m_cv, m_cs, m_clr;
  logic [4:0] m_rd;
  logic [31:0] m_val, m_pc;
  logic [3:0] m_id;
  function automatic bit inflight(int id);
    foreach (q[i]) if (q[i] == id) return 1;
    return 0;
  endfunction
  function automatic bit qr(int id);
    return inflight(id) && e[id].rdy;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    mtail = 0;
    {m_cv, m_cs, m_clr} = '0;
    m_rd = 0; m_val = 0; m_pc = 0; m_id = 0;
  endtask
  task automatic model_step();
    bit c, iss;
    int h;
    if (!rdy_in) return;
    if (m_clr) begin
      model_reset_keep();
      return;
    end
    c = q.size() > 0 && e[q[0]].rdy;
    iss = dc_valid && q.size() < N;
    m_cv = c;
    m_cs = 0;
    m_clr = 0;
    if (c) begin
      h = q[0];
      m_id = 4'(h);
      m_val = e[h].val;
      m_rd = e[h].t == 2 ? 5'd0 : e[h].rd;
      m_cs = e[h].t == 1;
      m_clr = e[h].t == 3 || (e[h].t == 2 && e[h].val[0] != e[h].p);
      if (m_clr) m_pc = e[h].t == 3 ? e[h].tgt : e[h].alt;
    end
    if (is_lsb && inflight(lsb_rob_id)) begin
      e[lsb_rob_id].rdy = 1;
      e[lsb_rob_id].val = lsb_res;
    end
    if (rs_has_output && inflight(rs_rob_id)) begin
      e[rs_rob_id].rdy = 1;
      e[rs_rob_id].val = rs_output;
      e[rs_rob_id].tgt = jalr_new_pc;
    end
    if (c) void'(q.pop_front());
    if (iss) begin
      e[mtail].rdy = dc_type == 1;
      e[mtail].t = dc_type;
      e[mtail].rd = dc_rd;
      e[mtail].p = dc_pred_taken;
      e[mtail].alt = dc_alt_pc;
      e[mtail].val = 0;
      e[mtail].tgt = 0;
      q.push_back(mtail);
      mtail = (mtail + 1) % N;
    end
  endtask
  task automatic model_reset_keep();
    q.delete();
    mtail = 0;
    m_clr = 0;
    m_cv = 0;
    m_cs = 0;
  endtask
  task automatic check_all();
    chk("full", rob_full, q.size() == N);
    chk("tail", rob_tail_id, mtail);
    chk("cvalid", commit_valid, m_cv);
    chk("cstore", commit_store, m_cs);
    chk("crd", commit_rd, m_rd);
    chk("cval", commit_val, m_val);
    chk("cid", commit_id, m_id);
    chk("clear", rob_clear, m_clr);
    chk("clear_pc", clear_pc, m_pc);
    chk("q1r", q1_ready, qr(q1_id));
    chk("q2r", q2_ready, qr(q2_id));
    if (qr(q1_id)) chk("q1v", q1_val, e[q1_id].val);
    if (qr(q2_id)) chk("q2v", q2_val, e[q2_id].val);
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk_in);
    #1;
    check_all();
  endtask
  task automatic quiet();
    dc_valid = 0; rs_has_output = 0; is_lsb = 0; rdy_in = 1;
  endtask
  task automatic issue(logic [1:0] t, logic [4:0] r, logic p, logic [31:0] alt);
    dc_valid = 1; dc_type = t; dc_rd = r; dc_pred_taken = p; dc_alt_pc = alt;
    cyc();
    dc_valid = 0;
  endtask
  task automatic rs_bc(int id, logic [31:0] v, logic [31:0] tgt);
    rs_has_output = 1; rs_rob_id = 4'(id); rs_output = v; jalr_new_pc = tgt;
  endtask
  task automatic drain();
    quiet();
    for (int i = 0; i < 60; i++) begin
      rs_has_output = 0;
      if (q.size() > 0 && !m_clr) rs_bc(q[0], 32'h10 + i, 0);
      rs_output[0] = 1'b0;
      cyc();
    end
    quiet();
  endtask
  task automatic rnd(bit fl);
    int c[$];
    int t;
    foreach (q[i]) if (!e[q[i]].rdy) c.push_back(q[i]);
    t = $urandom_range(0, 9);
    dc_valid = q.size() < N && !m_clr && $urandom_range(0, 2) != 0;
    dc_type = !fl ? 2'd0 : t < 6 ? 2'd0 : t < 8 ? 2'd1 : t < 9 ? 2'd2 : 2'd3;
    dc_rd = 5'($urandom);
    dc_pred_taken = 1'($urandom);
    dc_alt_pc = $urandom;
    rs_has_output = 1'($urandom);
    rs_rob_id = c.size() > 0 && $urandom_range(0, 3) != 0 ? 4'(c[$urandom_range(0, c.size() - 1)]) : 4'($urandom);
    rs_output = $urandom;
    jalr_new_pc = $urandom;
    is_lsb = $urandom_range(0, 2) == 0;
    lsb_rob_id = c.size() > 0 && $urandom_range(0, 1) != 0 ? 4'(c[$urandom_range(0, c.size() - 1)]) : 4'($urandom);
    if ($urandom_range(0, 4) == 0) lsb_rob_id = rs_rob_id;
    lsb_res = $urandom;
    q1_id = 4'($urandom);
    q2_id = c.size() > 0 ? 4'(q[$urandom_range(0, q.size() - 1)]) : 4'($urandom);
    rdy_in = $urandom_range(0, 9) != 0;
  endtask
  initial begin
    model_reset();
    #12;
    check_all();
    rst_n_in = 1;
    cyc();
    // single REG instruction completes and retires
    issue(0, 5, 0, 0);
    rs_bc(0, 32'h2A, 0);
    cyc();
    rs_has_output = 0;
    cyc();
    chk("r21_valid", commit_valid, 1);
    chk("r21_rd", commit_rd, 5);
    chk("r21_val", commit_val, 32'h2A);
    cyc();
    // out-of-order completion, in-order retirement
    issue(0, 1, 0, 0);
    issue(0, 2, 0, 0);
    rs_bc(2, 32'hB, 0);
    cyc();
    rs_has_output = 0;
    cyc();
    chk("r23_wait", commit_valid, 0);
    rs_bc(1, 32'hA, 0);
    cyc();
    rs_has_output = 0;
    cyc();
    chk("r23_id0", commit_id, 1);
    cyc();
    chk("r23_id1", commit_id, 2);
    chk("r23_v1", commit_valid, 1);
    cyc();
    // mispredicted branch flushes younger work
    issue(2, 7, 0, 32'h1000);
    issue(0, 9, 0, 0);
    rs_bc(3, 32'h1, 0);
    cyc();
    rs_bc(4, 32'h55, 0);
    cyc();
    chk("r24_clear", rob_clear, 1);
    chk("r24_pc", clear_pc, 32'h1000);
    chk("r24_rd", commit_rd, 0);
    dc_valid = 1;
    q1_id = 4;
    cyc();
    chk("r24_pulse", rob_clear, 0);
    chk("r24_tail", rob_tail_id, 0);
    chk("r24_q1", q1_ready, 0);
    quiet();
    cyc();
    // fill to full, then retire under a blocked same-cycle issue
    dc_valid = 1; dc_type = 0;
    for (int i = 0; i < N; i++) begin
      dc_rd = 5'(i);
      cyc();
    end
    chk("r22_full", rob_full, 1);
    rs_bc(0, 32'h77, 0);
    cyc();
    rs_has_output = 0;
    cyc();
    chk("r22_freed", rob_full, 0);
    chk("r22_commit", commit_valid, 1);
    cyc();
    chk("r22_refull", rob_full, 1);
    drain();
    // steady issue/commit pairs across the tail wrap
    for (int i = 0; i < 40; i++) begin
      dc_valid = 1; dc_type = 0; dc_rd = 5'(i);
      rs_has_output = 0;
      if (q.size() > 0) rs_bc(q[0], 32'h100 + i, 0);
      cyc();
    end
    drain();
    for (int i = 0; i < 500; i++) begin
      rnd(1);
      cyc();
    end
    drain();
    // asynchronous reset with entries in flight
    for (int i = 0; i < 6; i++) issue(0, 5'(i + 1), 0, 0);
    rs_bc(q[0], 32'hDEAD, 0);
    cyc();
    rs_has_output = 0;
    cyc();
    #3;
    rst_n_in = 0;
    #1;
    model_reset();
    chk("r26_tail", rob_tail_id, 0);
    chk("r26_valid", commit_valid, 0);
    chk("r26_val", commit_val, 0);
    check_all();
    #10;
    rst_n_in = 1;
    for (int i = 0; i < 60; i++) begin
      rnd(1);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, entry count (power of two).
REQ-002 SHALL have parameter ROB_W, default 4, log2(ROB_SIZE), width of every rob id.
REQ-003 SHALL have ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- dc_valid  in  1  issue one instruction this cycle; guaranteed only when rob_full=0.
- dc_type  in  2  0=REG, 1=STORE, 2=BRANCH, 3=JALR.
- dc_rd  in  5  destination register; 0 means no write.
- dc_pred_taken  in  1  predicted direction (BRANCH).
- dc_alt_pc  in  32  redirect target if prediction wrong (BRANCH).
- rob_full  out  1  no free entry.
- rob_tail_id  out  ROB_W  id the next issued instruction receives.
- rs_has_output, rs_rob_id, rs_output, jalr_new_pc  in  1/ROB_W/32/32  ALU result broadcast.
- is_lsb, lsb_rob_id, lsb_res  in  1/ROB_W/32  load result broadcast.
- q1_id, q2_id  in  ROB_W  operand queries from decoder.
- q1_ready, q2_ready  out  1  queried entry busy and result present.
- q1_val, q2_val  out  32  queried entry result.
- commit_valid  out  1  head retired this cycle (registered).
- commit_rd  out  5  retired destination.
- commit_val  out  32  retired value.
- commit_id  out  ROB_W  retired rob id.
- commit_store  out  1  retired entry is STORE; LSB may perform it.
- rob_clear  out  1  flush pulse to RS, LSB, decoder.
- clear_pc  out  32  fetch redirect target, valid with rob_clear.

Function
REQ-004 SHALL be a circular buffer: head, tail ROB_W bits wrapping ROB_SIZE-1 -> 0; count ROB_W+1 bits.
REQ-005 SHALL drive rob_full = (count == ROB_SIZE), rob_tail_id = tail, both combinational from state.
REQ-006 On dc_valid: entry[tail] busy=1, fields latched, tail+1, count+1; STORE entries ready=1 at issue, others ready=0.
REQ-007 On rs_has_output: entry[rs_rob_id] ready=1, value=rs_output, target=jalr_new_pc.
REQ-008 On is_lsb: entry[lsb_rob_id] ready=1, value=lsb_res; if both broadcasts hit one id, RS wins.
REQ-009 Query ports SHALL be combinational from stored state only (no same-cycle broadcast bypass).
REQ-010 Commit: when entry[head] busy and ready, retire exactly one per cycle: busy=0, head+1, count-1; commit_* registered, commit_valid high one cycle.
REQ-011 Issue and commit in the same cycle SHALL leave count unchanged; full blocks issue even if commit occurs.
REQ-012 BRANCH: taken = value[0]; commit_rd forced 0; mispredict when taken != pred_taken.
REQ-013 JALR: commit writes rd with value (pc+4); always flushes to stored target.
REQ-014 Mispredict or JALR commit SHALL register rob_clear=1 and clear_pc (alt_pc or target) for exactly one cycle after retirement.
REQ-015 In the rob_clear cycle: all busy=0, head=tail=0, count=0; dc_valid, broadcasts and commit ignored.
REQ-016 Broadcast to non-busy entry SHALL be ignored.

Reset
REQ-017 rst_n_in low SHALL asynchronously clear busy, head, tail, count, commit_valid, commit_store, rob_clear; commit_rd/val/id, clear_pc = 0.
REQ-018 Reset mid-flush SHALL drop rob_clear immediately; rdy_in low SHALL hold every register including pulses.

Structure
REQ-019 ROB_SIZE, ROB_W, dc_type codes SHALL live in the shared const package beside RS size constants.
REQ-020 Single module, no sub-modules; entry arrays as per-field register vectors.

Verification
REQ-021 Issue REG rd=5 id 0; RS broadcast id 0 value 0x2A -> next cycle commit_valid, commit_rd=5, commit_val=0x2A.
REQ-022 Issue 16 -> rob_full=1; complete head -> commit; same-cycle issue blocked until count=15.
REQ-023 Ids 0,1 issued; id 1 completes first -> no commit until id 0 completes; then commits 0 then 1 on consecutive cycles.
REQ-024 BRANCH pred_taken=0, alt_pc=0x1000, result 1 -> rob_clear one cycle, clear_pc=0x1000, count=0, younger results ignored.
REQ-025 Tail wraps at 15->0 over 40 issue/commit pairs; ids and commit order stay correct.
REQ-026 rst_n_in low mid-stream with 6 entries -> outputs zero without a clock edge, rob_tail_id=0.
